// File: rtl/prbs16_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs16_checker
//  Description : Checker for a 16-bit right-shift Fibonacci PRBS stream
//                (x^16+x^14+x^13+x^11+1). Hunts for a non-zero seed, confirms
//                LOCK_COUNT consecutive predictions, then flywheels the
//                predictor while counting mispredictions. After LOSS_COUNT
//                consecutive misses it drops lock and hunts again.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs16_checker #(
  parameter int LOCK_COUNT = 8,   // consecutive matches needed to lock (1..255)
  parameter int LOSS_COUNT = 4    // consecutive misses that drop lock (1..255)
) (
  input  logic        CLK,
  input  logic        n_RESET,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  input  logic        clear_err,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  // --------------------------------------------------------------------------
  // State encoding and counter targets
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [7:0]  c_LOCK_TGT = 8'(LOCK_COUNT);
  localparam logic [7:0]  c_LOSS_TGT = 8'(LOSS_COUNT);
  localparam logic [15:0] c_ERR_MAX  = 16'hFFFF;

  // Successor of an LFSR state word: feedback enters at the MSB, the word
  // shifts right by one.
  function automatic logic [15:0] prbs_next(input logic [15:0] x);
    prbs_next = {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [15:0] r_expected;
  logic [7:0]  r_match_cnt;
  logic [7:0]  r_miss_cnt;
  logic        r_locked;
  logic        r_err_pulse;
  logic [15:0] r_err_count;

  // --------------------------------------------------------------------------
  // Combinational next values
  // --------------------------------------------------------------------------
  logic [1:0]  w_state_next;
  logic [15:0] w_expected_next;
  logic [7:0]  w_match_next;
  logic [7:0]  w_miss_next;
  logic        w_locked_next;
  logic        w_err_hit;
  logic [15:0] w_err_count_next;

  logic        w_hit;
  logic        w_data_zero;
  logic [7:0]  w_match_inc;
  logic [7:0]  w_miss_inc;

  assign w_hit       = (data_in == r_expected);
  assign w_data_zero = (data_in == 16'h0000);
  assign w_match_inc = r_match_cnt + 8'd1;
  assign w_miss_inc  = r_miss_cnt + 8'd1;

  // State register: HUNT out of reset.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and predictor/counter update; idle cycles hold everything.
  always_comb begin
    w_state_next    = r_state;
    w_expected_next = r_expected;
    w_match_next    = r_match_cnt;
    w_miss_next     = r_miss_cnt;
    if (valid_in) begin
      case (r_state)
        S_HUNT: begin
          // The all-zero word is the LFSR lock-up state and cannot seed.
          if (!w_data_zero) begin
            w_expected_next = prbs_next(data_in);
            w_match_next    = 8'd0;
            w_state_next    = S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_hit) begin
            w_expected_next = prbs_next(data_in);
            w_match_next    = w_match_inc;
            if (w_match_inc == c_LOCK_TGT) begin
              w_state_next = S_LOCKED;
              w_miss_next  = 8'd0;
            end
          end else if (w_data_zero) begin
            w_match_next = 8'd0;
            w_state_next = S_HUNT;
          end else begin
            // Restart confirmation from the new sample.
            w_expected_next = prbs_next(data_in);
            w_match_next    = 8'd0;
          end
        end
        S_LOCKED: begin
          // Flywheel: corrupted input must not disturb the predictor.
          w_expected_next = prbs_next(r_expected);
          if (w_hit) begin
            w_miss_next = 8'd0;
          end else begin
            w_miss_next = w_miss_inc;
            if (w_miss_inc == c_LOSS_TGT) begin
              w_state_next = S_HUNT;
              w_match_next = 8'd0;
            end
          end
        end
        default: begin
          w_state_next = S_HUNT;
        end
      endcase
    end
  end

  // Output decode: lock flag follows the next state, errors only count while locked.
  always_comb begin
    w_locked_next    = (w_state_next == S_LOCKED);
    w_err_hit        = valid_in && (r_state == S_LOCKED) && !w_hit;
    w_err_count_next = r_err_count;
    if (clear_err) begin
      w_err_count_next = 16'h0000;
    end else if (w_err_hit && (r_err_count != c_ERR_MAX)) begin
      w_err_count_next = r_err_count + 16'd1;
    end
  end

  // Predictor word and match/miss counters.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_expected  <= 16'h0000;
      r_match_cnt <= 8'd0;
      r_miss_cnt  <= 8'd0;
    end else begin
      r_expected  <= w_expected_next;
      r_match_cnt <= w_match_next;
      r_miss_cnt  <= w_miss_next;
    end
  end

  // Registered status outputs.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= 16'h0000;
    end else begin
      r_locked    <= w_locked_next;
      r_err_pulse <= w_err_hit;
      r_err_count <= w_err_count_next;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs16_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs16_checker
//  Description : Scoreboard bench for prbs16_checker. Two instances: A with
//                default parameters, B with LOSS_COUNT=255 for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs16_checker;

  logic        CLK;
  logic        n_RESET;
  logic        valid_in;
  logic [15:0] data_in;
  logic        clear_err;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_count_a;
  logic        locked_b, err_pulse_b;
  logic [15:0] err_count_b;

  prbs16_checker u_dut_a (
    .CLK       (CLK),
    .n_RESET   (n_RESET),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .clear_err (clear_err),
    .locked    (locked_a),
    .err_pulse (err_pulse_a),
    .err_count (err_count_a)
  );

  prbs16_checker #(.LOCK_COUNT(8), .LOSS_COUNT(255)) u_dut_b (
    .CLK       (CLK),
    .n_RESET   (n_RESET),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .clear_err (clear_err),
    .locked    (locked_b),
    .err_pulse (err_pulse_b),
    .err_count (err_count_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    string       nm;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] cur;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock for whichever instance is under test.
  always @(negedge CLK) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk({ea.nm, ".A.locked"},    {15'd0, locked_a},    {15'd0, ea.lk});
      chk({ea.nm, ".A.err_pulse"}, {15'd0, err_pulse_a}, {15'd0, ea.ep});
      chk({ea.nm, ".A.err_count"}, err_count_a,          ea.ec);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk({eb.nm, ".B.locked"},    {15'd0, locked_b},    {15'd0, eb.lk});
      chk({eb.nm, ".B.err_pulse"}, {15'd0, err_pulse_b}, {15'd0, eb.ep});
      chk({eb.nm, ".B.err_count"}, err_count_b,          eb.ec);
    end
  end

  // One clock of stimulus; the expectation describes outputs after the edge.
  task automatic step(input int which, input logic v, input logic [15:0] d, input logic clr,
                      input logic el, input logic ep, input logic [15:0] ec, input string nm);
    exp_t e;
    valid_in  = v;
    data_in   = d;
    clear_err = clr;
    @(posedge CLK);
    e.lk = el; e.ep = ep; e.ec = ec; e.nm = nm;
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
    @(negedge CLK);
  endtask

  // Unchecked clock, used for the long error preload.
  task automatic bulk(input logic [15:0] d);
    valid_in  = 1'b1;
    data_in   = d;
    clear_err = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic good(input int which, input logic el, input logic ep, input logic [15:0] ec, input string nm);
    step(which, 1'b1, cur, 1'b0, el, ep, ec, nm);
    cur = lfsr_next(cur);
  endtask

  task automatic bad(input int which, input logic clr, input logic el, input logic ep, input logic [15:0] ec, input string nm);
    step(which, 1'b1, cur ^ 16'h0001, clr, el, ep, ec, nm);
    cur = lfsr_next(cur);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse(input string nm);
    valid_in  = 1'b0;
    clear_err = 1'b0;
    #2 n_RESET = 1'b0;
    #1;
    chk({nm, ".A.locked"},    {15'd0, locked_a}, 16'd0);
    chk({nm, ".A.err_count"}, err_count_a,       16'd0);
    chk({nm, ".B.locked"},    {15'd0, locked_b}, 16'd0);
    #1 n_RESET = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    n_RESET   = 1'b0;
    valid_in  = 1'b0;
    data_in   = 16'h0000;
    clear_err = 1'b0;
    @(negedge CLK);

    // Reset state, including a valid sample presented while held in reset
    step(0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_idle");
    step(0, 1'b1, 16'hACE1, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_valid");
    n_RESET = 1'b1;

    // Acquire from seed 0xACE1: seed + 8 matches, lock after the 9th sample
    cur = 16'hACE1;
    for (int i = 0; i < 9; i++) good(0, (i == 8), 1'b0, 16'h0000, $sformatf("acq%0d", i));
    for (int i = 0; i < 3; i++) good(0, 1'b1, 1'b0, 16'h0000, "hold");

    // Single corrupted sample while locked
    bad(0, 1'b0, 1'b1, 1'b1, 16'd1, "one_err");
    for (int i = 0; i < 3; i++) good(0, 1'b1, 1'b0, 16'd1, "after_err");

    // Synchronous clear on an idle cycle
    step(0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd0, "clear_idle");

    // Four consecutive misses drop lock after the fourth
    bad(0, 1'b0, 1'b1, 1'b1, 16'd1, "loss1");
    bad(0, 1'b0, 1'b1, 1'b1, 16'd2, "loss2");
    bad(0, 1'b0, 1'b1, 1'b1, 16'd3, "loss3");
    bad(0, 1'b0, 1'b0, 1'b1, 16'd4, "loss4");
    for (int i = 0; i < 9; i++) good(0, (i == 8), 1'b0, 16'd4, $sformatf("relock%0d", i));

    // Reset mid-lock
    reset_pulse("midlock_rst");
    step(0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, "post_rst");

    // valid_in toggling: 9 valid samples to lock, idle cycles change nothing
    cur = 16'hACE1;
    for (int i = 0; i < 9; i++) begin
      good(0, (i == 8), 1'b0, 16'd0, $sformatf("tog%0d", i));
      step(0, 1'b0, 16'h0BAD, 1'b0, (i == 8), 1'b0, 16'd0, $sformatf("tog_idle%0d", i));
    end

    // All-zero stream never seeds
    reset_pulse("zero_rst");
    for (int i = 0; i < 20; i++) step(0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, "zeros");

    // Mismatch during SYNC reseeds; 8 fresh matches needed afterwards
    cur = 16'hACE1;
    for (int i = 0; i < 4; i++) good(0, 1'b0, 1'b0, 16'd0, "sync_pre");
    cur = 16'h1234;
    good(0, 1'b0, 1'b0, 16'd0, "reseed");
    for (int i = 0; i < 8; i++) good(0, (i == 7), 1'b0, 16'd0, $sformatf("reseed_m%0d", i));

    // Instance B: saturation and clear priority
    reset_pulse("b_rst");
    cur = 16'hACE1;
    for (int i = 0; i < 9; i++) good(1, (i == 8), 1'b0, 16'd0, $sformatf("b_acq%0d", i));
    for (int r = 0; r < 258; r++) begin
      for (int k = 0; k < 254; k++) begin
        bulk(cur ^ 16'h0001);
        cur = lfsr_next(cur);
      end
      bulk(cur);
      cur = lfsr_next(cur);
    end
    good(1, 1'b1, 1'b0, 16'hFFFC, "b_preload");
    bad(1, 1'b0, 1'b1, 1'b1, 16'hFFFD, "b_sat1");
    bad(1, 1'b0, 1'b1, 1'b1, 16'hFFFE, "b_sat2");
    bad(1, 1'b0, 1'b1, 1'b1, 16'hFFFF, "b_sat3");
    bad(1, 1'b0, 1'b1, 1'b1, 16'hFFFF, "b_sat4");
    bad(1, 1'b0, 1'b1, 1'b1, 16'hFFFF, "b_sat5");
    bad(1, 1'b1, 1'b1, 1'b1, 16'h0000, "b_clr_win");
    good(1, 1'b1, 1'b0, 16'h0000, "b_after_clr");

    @(posedge CLK);
    @(negedge CLK);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs16_checker.md
PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 8, is the number of consecutive correctly predicted valid samples required to declare lock (legal range 1..255).
REQ-002 Parameter LOSS_COUNT, default 4, is the number of consecutive mispredicted valid samples while locked that forces loss of lock (legal range 1..255).
REQ-003 CLK  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 n_RESET  input  1  is the reset, asynchronous and active-low.
REQ-005 valid_in  input  1  marks data_in as a new sample this cycle.
REQ-006 data_in  input  16  is the sampled state word of the upstream 16-bit LFSR.
REQ-007 clear_err  input  1  is a synchronous clear of err_count.
REQ-008 locked  output  1  is high while the FSM is in LOCKED.
REQ-009 err_pulse  output  1  is a one-cycle flag for a mispredicted sample while locked.
REQ-010 err_count  output  16  is the saturating count of mispredicted samples while locked.

Function
REQ-011 The prediction function SHALL be next(x) = {x[0]^x[2]^x[3]^x[5], x[15:1]}, the right-shift Fibonacci form of x^16+x^14+x^13+x^11+1; next(0xACE1) = 0x5670.
REQ-012 Cycles with valid_in low SHALL leave all state, counters and the expected word unchanged, and err_pulse SHALL be low in the following cycle.
REQ-013 The FSM SHALL have exactly three states: HUNT, SYNC and LOCKED.
REQ-014 HUNT, valid non-zero sample: expected <= next(data_in), match_cnt <= 0, go to SYNC; a valid 0x0000 sample SHALL be ignored and the FSM SHALL stay in HUNT.
REQ-015 SYNC, valid sample equal to expected: match_cnt increments, expected <= next(data_in); when the incremented match_cnt equals LOCK_COUNT, the FSM SHALL go to LOCKED with miss_cnt <= 0.
REQ-016 SYNC, valid sample not equal to expected: the FSM SHALL reseed (expected <= next(data_in), match_cnt <= 0) and stay in SYNC, or go to HUNT if data_in is 0x0000.
REQ-017 LOCKED, valid sample: expected <= next(expected), i.e. flywheel with no reseed from data_in.
REQ-018 LOCKED, match: miss_cnt <= 0.
REQ-019 LOCKED, mismatch: err_pulse is high in the next cycle, err_count increments, and miss_cnt increments.
REQ-020 LOCKED, mismatch where the incremented miss_cnt equals LOSS_COUNT: the FSM SHALL go to HUNT and match_cnt <= 0.
REQ-021 locked SHALL be registered, rising the cycle after the LOCK_COUNT-th match and falling the cycle after the LOSS_COUNT-th consecutive miss.
REQ-022 err_count SHALL saturate at 0xFFFF and never wrap.
REQ-023 When clear_err is high in the same cycle as an increment, clear SHALL win and err_count SHALL be 0x0000.
REQ-024 Mismatches in HUNT or SYNC SHALL NOT assert err_pulse or change err_count.

Reset
REQ-025 When n_RESET is low, the block SHALL immediately force: state HUNT, locked 0, err_pulse 0, err_count 0x0000, match_cnt 0, miss_cnt 0, expected 0x0000, regardless of CLK.
REQ-026 Reset asserted mid-lock SHALL abandon lock at once, and after deassertion the block SHALL reacquire from HUNT per REQ-014.
REQ-027 Reset deassertion SHALL take effect on the first rising CLK edge after n_RESET goes high.

Verification
REQ-028 Reset, then a valid_in-every-cycle stream from seed 0xACE1 (0xACE1, 0x5670, ...) -> locked rises the cycle after the 9th sample (1 seed + 8 matches); err_count stays 0.
REQ-029 Locked stream, one sample corrupted (bit 0 flipped), then a correct stream -> exactly one err_pulse, err_count = 1, locked stays high.
REQ-030 Locked stream replaced by 4 consecutive wrong samples -> err_count = 4 and locked falls after the 4th wrong sample; a resumed correct stream relocks after 9 samples.
REQ-031 Stream with valid_in toggling 1/0 -> lock is achieved after 9 valid samples, and idle cycles change nothing.
REQ-032 err_count preloaded near 0xFFFF via sustained errors with LOSS_COUNT=255 -> err_count holds at 0xFFFF; clear_err asserted together with an error -> err_count = 0x0000.
REQ-033 n_RESET pulsed low between clock edges while locked -> locked and err_count are 0 before the next CLK edge; a stream of 0x0000 samples -> the FSM stays in HUNT indefinitely.
